// File: rtl/i2c_pkg.sv
// i2c_pkg: definitions shared by the I2C target controller and the master-side code.
//   i2c_slv_state_e : target-side protocol state
//   I2C_ACK/I2C_NACK: level of the SDA bit in the ninth (acknowledge) clock
package i2c_pkg;

  typedef enum logic [3:0] {
    ST_IDLE     = 4'd0,
    ST_ADDR     = 4'd1,
    ST_ADDR_ACK = 4'd2,
    ST_RX       = 4'd3,
    ST_RX_ACK   = 4'd4,
    ST_TX_WAIT  = 4'd5,
    ST_TX       = 4'd6,
    ST_TX_ACK   = 4'd7,
    ST_IGNORE   = 4'd8
  } i2c_slv_state_e;

  localparam logic I2C_ACK  = 1'b0;
  localparam logic I2C_NACK = 1'b1;

endpackage

// File: rtl/i2c_slave_if.sv
// i2c_slave_if: host-side byte handshake of the I2C target.
//   rx_data/rx_tick          : received byte and its one-cycle valid pulse
//   tx_req/tx_data/tx_valid  : read-byte request and host reply
//   start/stop/nack_tick     : bus event pulses
//   rd_mode/busy             : direction and activity of the matched transfer
// Modport slave is the controller view, master is the host view.
interface i2c_slave_if;

  logic [7:0] rx_data;
  logic       rx_tick;
  logic       tx_req;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       start_tick;
  logic       stop_tick;
  logic       nack_tick;
  logic       rd_mode;
  logic       busy;

  modport slave (
    output rx_data, rx_tick, tx_req, start_tick, stop_tick, nack_tick, rd_mode, busy,
    input  tx_data, tx_valid
  );

  modport master (
    input  rx_data, rx_tick, tx_req, start_tick, stop_tick, nack_tick, rd_mode, busy,
    output tx_data, tx_valid
  );

endinterface

// File: rtl/i2c_sync_edge.sv
// i2c_sync_edge: two-flop synchronizer for an asynchronous bus pin, followed by
// a previous-sample register from which one-cycle rise/fall pulses are derived.
//   clk, reset : system clock, synchronous active-low reset
//   pin_i      : raw pin
//   lvl_o      : synchronized level
//   rise_o     : one-cycle pulse on a synchronized 0->1 transition
//   fall_o     : one-cycle pulse on a synchronized 1->0 transition
module i2c_sync_edge (
  input  logic clk,
  input  logic reset,
  input  logic pin_i,
  output logic lvl_o,
  output logic rise_o,
  output logic fall_o
);

  logic ff1_q;
  logic ff2_q;
  logic prev_q;

  // Synchronizer chain; resets to the idle (pulled-up) bus level so that
  // leaving reset on an idle bus produces no edge.
  always_ff @(posedge clk) begin
    if (!reset) begin
      ff1_q  <= 1'b1;
      ff2_q  <= 1'b1;
      prev_q <= 1'b1;
    end else begin
      ff1_q  <= pin_i;
      ff2_q  <= ff1_q;
      prev_q <= ff2_q;
    end
  end

  assign lvl_o  = ff2_q;
  assign rise_o = ff2_q & ~prev_q;
  assign fall_o = ~ff2_q & prev_q;

endmodule

// File: rtl/i2c_slave.sv
// i2c_slave: I2C target controller with a fixed 7-bit address.
//   clk, reset : system clock (>= 16x SCL), synchronous active-low reset
//   scl, sda   : open-drain bus lines, only ever pulled low
//   hif        : host byte interface (received bytes, read-byte handshake,
//                event pulses, rd_mode and busy)
// Reads stretch SCL in TX_WAIT until the host supplies each byte.
module i2c_slave
  import i2c_pkg::*;
#(
  parameter logic [6:0] DEV_ADDR = 7'h42
) (
  input  logic        clk,
  input  logic        reset,
  inout  tri          scl,
  inout  tri          sda,
  i2c_slave_if.slave  hif
);

  logic scl_lvl, scl_rise, scl_fall;
  logic sda_lvl, sda_rise, sda_fall;

  i2c_sync_edge u_scl_sync (.clk(clk), .reset(reset), .pin_i(scl),
                            .lvl_o(scl_lvl), .rise_o(scl_rise), .fall_o(scl_fall));
  i2c_sync_edge u_sda_sync (.clk(clk), .reset(reset), .pin_i(sda),
                            .lvl_o(sda_lvl), .rise_o(sda_rise), .fall_o(sda_fall));

  logic start_ev, stop_ev;
  assign start_ev = sda_fall & scl_lvl;
  assign stop_ev  = sda_rise & scl_lvl;

  i2c_slv_state_e state_q, state_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] shift_q, shift_d;
  logic [7:0] rx_data_q, rx_data_d;
  // Set when a byte (or a master ACK) has completed on a rising edge; the
  // following SCL fall then performs the phase change.
  logic       pend_q, pend_d;
  logic       rx_tick_q, rx_tick_d;
  logic       start_tick_q, start_tick_d;
  logic       stop_tick_q, stop_tick_d;
  logic       nack_tick_q, nack_tick_d;
  logic       tx_req_q, tx_req_d;
  logic       rd_mode_q, rd_mode_d;
  logic       busy_q, busy_d;
  logic       scl_low_q, scl_low_d;
  logic       sda_low_q, sda_low_d;

  // State and output register.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      bit_cnt_q    <= 3'd0;
      shift_q      <= 8'h00;
      rx_data_q    <= 8'h00;
      pend_q       <= 1'b0;
      rx_tick_q    <= 1'b0;
      start_tick_q <= 1'b0;
      stop_tick_q  <= 1'b0;
      nack_tick_q  <= 1'b0;
      tx_req_q     <= 1'b0;
      rd_mode_q    <= 1'b0;
      busy_q       <= 1'b0;
      scl_low_q    <= 1'b0;
      sda_low_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      rx_data_q    <= rx_data_d;
      pend_q       <= pend_d;
      rx_tick_q    <= rx_tick_d;
      start_tick_q <= start_tick_d;
      stop_tick_q  <= stop_tick_d;
      nack_tick_q  <= nack_tick_d;
      tx_req_q     <= tx_req_d;
      rd_mode_q    <= rd_mode_d;
      busy_q       <= busy_d;
      scl_low_q    <= scl_low_d;
      sda_low_q    <= sda_low_d;
    end
  end

  // Next-state logic; START/STOP take priority over every protocol state.
  always_comb begin
    state_d      = state_q;
    bit_cnt_d    = bit_cnt_q;
    shift_d      = shift_q;
    rx_data_d    = rx_data_q;
    pend_d       = pend_q;
    rx_tick_d    = 1'b0;
    start_tick_d = 1'b0;
    stop_tick_d  = 1'b0;
    nack_tick_d  = 1'b0;
    tx_req_d     = 1'b0;
    rd_mode_d    = rd_mode_q;
    busy_d       = busy_q;
    scl_low_d    = scl_low_q;
    sda_low_d    = sda_low_q;

    if (start_ev || stop_ev) begin
      state_d      = start_ev ? ST_ADDR : ST_IDLE;
      bit_cnt_d    = 3'd0;
      pend_d       = 1'b0;
      busy_d       = 1'b0;
      scl_low_d    = 1'b0;
      sda_low_d    = 1'b0;
      start_tick_d = start_ev;
      stop_tick_d  = ~start_ev;
    end else begin
      case (state_q)
        ST_ADDR, ST_RX: begin
          if (scl_rise) begin
            shift_d   = {shift_q[6:0], sda_lvl};
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              pend_d = 1'b1;
              if (state_q == ST_RX) begin
                rx_data_d = {shift_q[6:0], sda_lvl};
                rx_tick_d = 1'b1;
              end else begin
                rx_data_d = rx_data_q;
              end
            end else begin
              pend_d = pend_q;
            end
          end else if (scl_fall && pend_q) begin
            pend_d = 1'b0;
            if (state_q == ST_RX) begin
              sda_low_d = 1'b1;
              state_d   = ST_RX_ACK;
            end else if (shift_q[7:1] == DEV_ADDR) begin
              sda_low_d = 1'b1;
              rd_mode_d = shift_q[0];
              busy_d    = 1'b1;
              state_d   = ST_ADDR_ACK;
            end else begin
              state_d = ST_IGNORE;
            end
          end else begin
            pend_d = pend_q;
          end
        end
        ST_ADDR_ACK: begin
          if (scl_fall) begin
            sda_low_d = 1'b0;
            state_d   = rd_mode_q ? ST_TX_WAIT : ST_RX;
            scl_low_d = rd_mode_q;
          end else begin
            state_d = ST_ADDR_ACK;
          end
        end
        ST_RX_ACK: begin
          if (scl_fall) begin
            sda_low_d = 1'b0;
            state_d   = ST_RX;
          end else begin
            state_d = ST_RX_ACK;
          end
        end
        ST_TX_WAIT: begin
          scl_low_d = 1'b1;
          if (tx_req_q && hif.tx_valid) begin
            // Present bit 7 now; SCL is let go on the following cycle in TX.
            shift_d   = hif.tx_data;
            sda_low_d = ~hif.tx_data[7];
            bit_cnt_d = 3'd0;
            state_d   = ST_TX;
          end else begin
            tx_req_d = 1'b1;
          end
        end
        ST_TX: begin
          scl_low_d = 1'b0;
          if (scl_fall) begin
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              sda_low_d = 1'b0;
              pend_d    = 1'b0;
              state_d   = ST_TX_ACK;
            end else begin
              shift_d   = {shift_q[6:0], 1'b0};
              sda_low_d = ~shift_q[6];
            end
          end else begin
            state_d = ST_TX;
          end
        end
        ST_TX_ACK: begin
          if (scl_rise) begin
            if (sda_lvl == I2C_NACK) begin
              nack_tick_d = 1'b1;
              state_d     = ST_IGNORE;
            end else begin
              pend_d = 1'b1;
            end
          end else if (scl_fall && pend_q) begin
            pend_d    = 1'b0;
            scl_low_d = 1'b1;
            state_d   = ST_TX_WAIT;
          end else begin
            pend_d = pend_q;
          end
        end
        ST_IDLE, ST_IGNORE: begin
          scl_low_d = 1'b0;
          sda_low_d = 1'b0;
        end
        default: begin
          state_d   = ST_IDLE;
          scl_low_d = 1'b0;
          sda_low_d = 1'b0;
        end
      endcase
    end
  end

  assign scl = scl_low_q ? 1'b0 : 1'bz;
  assign sda = sda_low_q ? 1'b0 : 1'bz;

  assign hif.rx_data    = rx_data_q;
  assign hif.rx_tick    = rx_tick_q;
  assign hif.tx_req     = tx_req_q;
  assign hif.start_tick = start_tick_q;
  assign hif.stop_tick  = stop_tick_q;
  assign hif.nack_tick  = nack_tick_q;
  assign hif.rd_mode    = rd_mode_q;
  assign hif.busy       = busy_q;

endmodule

// File: tb/tb_i2c_slave.sv
// tb_i2c_slave: directed bench for i2c_slave. A bus-level master model drives
// SCL/SDA through pull-ups; a host task answers read requests.
module tb_i2c_slave;
  import i2c_pkg::*;

  localparam int Q = 10;   // clk cycles per quarter SCL period

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic m_scl_low = 1'b0;
  logic m_sda_low = 1'b0;
  wire  scl;
  wire  sda;

  pullup (scl);
  pullup (sda);
  assign scl = m_scl_low ? 1'b0 : 1'bz;
  assign sda = m_sda_low ? 1'b0 : 1'bz;

  i2c_slave_if hif ();

  i2c_slave #(.DEV_ADDR(7'h42)) dut (
    .clk   (clk),
    .reset (reset),
    .scl   (scl),
    .sda   (sda),
    .hif   (hif)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Event counters, observed only.
  int rx_ticks = 0, start_ticks = 0, stop_ticks = 0, nack_ticks = 0;
  int tx_req_rises = 0, slv_sda_low_cnt = 0;
  bit tx_req_prev = 1'b0;

  always @(posedge clk) begin
    tx_req_prev <= hif.tx_req;
    if (hif.rx_tick    === 1'b1) rx_ticks    <= rx_ticks + 1;
    if (hif.start_tick === 1'b1) start_ticks <= start_ticks + 1;
    if (hif.stop_tick  === 1'b1) stop_ticks  <= stop_ticks + 1;
    if (hif.nack_tick  === 1'b1) nack_ticks  <= nack_ticks + 1;
    if (hif.tx_req === 1'b1 && !tx_req_prev) tx_req_rises <= tx_req_rises + 1;
    if (sda === 1'b0 && !m_sda_low) slv_sda_low_cnt <= slv_sda_low_cnt + 1;
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic qwait();
    repeat (Q) @(negedge clk);
  endtask

  task automatic wait_scl_high();
    int t = 0;
    while (scl !== 1'b1 && t < 3000) begin
      @(negedge clk);
      t++;
    end
    if (scl !== 1'b1) check_eq("scl_release_timeout", 32'(scl), 32'd1);
  endtask

  // START or repeated START, leaves SCL low.
  task automatic m_start();
    m_sda_low = 1'b0;
    qwait();
    m_scl_low = 1'b0;
    wait_scl_high();
    qwait();
    m_sda_low = 1'b1;
    qwait();
    m_scl_low = 1'b1;
  endtask

  task automatic m_stop();
    qwait();
    m_sda_low = 1'b1;
    qwait();
    m_scl_low = 1'b0;
    wait_scl_high();
    qwait();
    m_sda_low = 1'b0;
    qwait();
    qwait();
  endtask

  task automatic m_bit(input logic b, output logic s);
    qwait();
    m_sda_low = ~b;
    qwait();
    m_scl_low = 1'b0;
    wait_scl_high();
    qwait();
    s = sda;
    qwait();
    m_scl_low = 1'b1;
  endtask

  task automatic m_write_byte(input logic [7:0] d, output logic ack);
    logic dummy;
    for (int i = 7; i >= 0; i--) m_bit(d[i], dummy);
    m_bit(1'b1, ack);
  endtask

  task automatic m_read_byte(input logic ack_bit, output logic [7:0] d);
    logic dummy;
    for (int i = 7; i >= 0; i--) m_bit(1'b1, d[i]);
    m_bit(ack_bit, dummy);
  endtask

  // Wait for tx_req, stall dly cycles (SCL must stay low), then hand over d.
  task automatic host_supply(input logic [7:0] d, input int dly);
    int t = 0;
    int held = 0;
    while (hif.tx_req !== 1'b1 && t < 5000) begin
      @(negedge clk);
      t++;
    end
    check_eq("tx_req_seen", 32'(hif.tx_req), 32'd1);
    repeat (dly) begin
      @(negedge clk);
      if (scl === 1'b0) held++;
    end
    check_eq("scl_stretch_cycles", 32'(held), 32'(dly));
    hif.tx_data  = d;
    hif.tx_valid = 1'b1;
    @(negedge clk);
    check_eq("scl_held_at_accept", 32'(scl), 32'd0);
    @(negedge clk);
    check_eq("scl_released_after_accept", 32'(scl), 32'd1);
    check_eq("tx_req_dropped", 32'(hif.tx_req), 32'd0);
    hif.tx_valid = 1'b0;
  endtask

  initial begin
    logic       ack;
    logic [7:0] rd0, rd1;
    int s_rx, s_start, s_stop, s_nack, s_txr, s_sda;

    hif.tx_data  = 8'h00;
    hif.tx_valid = 1'b0;
    reset = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check_eq("rst_rx_data", 32'(hif.rx_data), 32'h00);
    check_eq("rst_tx_req",  32'(hif.tx_req),  32'd0);
    check_eq("rst_busy",    32'(hif.busy),    32'd0);
    check_eq("rst_rd_mode", 32'(hif.rd_mode), 32'd0);
    check_eq("rst_ticks",   32'({hif.rx_tick, hif.start_tick, hif.stop_tick, hif.nack_tick}), 32'd0);
    check_eq("rst_lines",   32'({scl, sda}), 32'b11);

    // Write 0x42: 0xA5, 0x3C.
    s_rx = rx_ticks; s_stop = stop_ticks; s_start = start_ticks;
    m_start();
    m_write_byte(8'h84, ack);
    check_eq("w_addr_ack", 32'(ack), 32'(I2C_ACK));
    check_eq("w_busy", 32'(hif.busy), 32'd1);
    check_eq("w_rd_mode", 32'(hif.rd_mode), 32'd0);
    m_write_byte(8'hA5, ack);
    check_eq("w_data0_ack", 32'(ack), 32'(I2C_ACK));
    check_eq("w_rx_data0", 32'(hif.rx_data), 32'hA5);
    m_write_byte(8'h3C, ack);
    check_eq("w_data1_ack", 32'(ack), 32'(I2C_ACK));
    check_eq("w_rx_data1", 32'(hif.rx_data), 32'h3C);
    m_stop();
    check_eq("w_rx_ticks", 32'(rx_ticks - s_rx), 32'd2);
    check_eq("w_start_ticks", 32'(start_ticks - s_start), 32'd1);
    check_eq("w_stop_ticks", 32'(stop_ticks - s_stop), 32'd1);
    check_eq("w_busy_after_stop", 32'(hif.busy), 32'd0);

    // Foreign address 0x43: never acknowledged.
    s_rx = rx_ticks; s_sda = slv_sda_low_cnt;
    m_start();
    m_write_byte(8'h86, ack);
    check_eq("x_addr_nack", 32'(ack), 32'(I2C_NACK));
    check_eq("x_busy", 32'(hif.busy), 32'd0);
    m_write_byte(8'h55, ack);
    check_eq("x_data_nack", 32'(ack), 32'(I2C_NACK));
    m_stop();
    check_eq("x_sda_never_low", 32'(slv_sda_low_cnt - s_sda), 32'd0);
    check_eq("x_rx_ticks", 32'(rx_ticks - s_rx), 32'd0);

    // Single-byte read 0x96, host answers 20 cycles late, master NACKs.
    s_nack = nack_ticks; s_txr = tx_req_rises;
    m_start();
    m_write_byte(8'h85, ack);
    check_eq("r_addr_ack", 32'(ack), 32'(I2C_ACK));
    check_eq("r_rd_mode", 32'(hif.rd_mode), 32'd1);
    check_eq("r_busy", 32'(hif.busy), 32'd1);
    fork
      m_read_byte(I2C_NACK, rd0);
      host_supply(8'h96, 20);
    join
    check_eq("r_data", 32'(rd0), 32'h96);
    check_eq("r_nack_tick", 32'(nack_ticks - s_nack), 32'd1);
    m_stop();
    check_eq("r_no_more_tx_req", 32'(tx_req_rises - s_txr), 32'd1);
    check_eq("r_tx_req_low", 32'(hif.tx_req), 32'd0);

    // Two-byte read 0x01 (ACK) then 0xFE (NACK).
    s_nack = nack_ticks; s_txr = tx_req_rises;
    m_start();
    m_write_byte(8'h85, ack);
    check_eq("r2_addr_ack", 32'(ack), 32'(I2C_ACK));
    fork
      m_read_byte(I2C_ACK, rd0);
      host_supply(8'h01, 20);
    join
    check_eq("r2_data0", 32'(rd0), 32'h01);
    check_eq("r2_no_nack_yet", 32'(nack_ticks - s_nack), 32'd0);
    fork
      m_read_byte(I2C_NACK, rd1);
      host_supply(8'hFE, 24);
    join
    check_eq("r2_data1", 32'(rd1), 32'hFE);
    m_stop();
    check_eq("r2_nack_tick", 32'(nack_ticks - s_nack), 32'd1);
    check_eq("r2_tx_req_count", 32'(tx_req_rises - s_txr), 32'd2);

    // Write 0x11, repeated START, read address; then reset while stretching.
    s_start = start_ticks;
    m_start();
    m_write_byte(8'h84, ack);
    m_write_byte(8'h11, ack);
    check_eq("rs_data_ack", 32'(ack), 32'(I2C_ACK));
    check_eq("rs_rx_data", 32'(hif.rx_data), 32'h11);
    check_eq("rs_rd_mode_w", 32'(hif.rd_mode), 32'd0);
    m_start();
    m_write_byte(8'h85, ack);
    check_eq("rs_addr_ack", 32'(ack), 32'(I2C_ACK));
    check_eq("rs_rd_mode_r", 32'(hif.rd_mode), 32'd1);
    check_eq("rs_start_ticks", 32'(start_ticks - s_start), 32'd2);
    qwait();
    m_scl_low = 1'b0;
    qwait();
    check_eq("rs_tx_req", 32'(hif.tx_req), 32'd1);
    check_eq("rs_scl_stretched", 32'(scl), 32'd0);

    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    check_eq("mid_rst_lines", 32'({scl, sda}), 32'b11);
    check_eq("mid_rst_tx_req", 32'(hif.tx_req), 32'd0);
    check_eq("mid_rst_busy", 32'(hif.busy), 32'd0);
    check_eq("mid_rst_rd_mode", 32'(hif.rd_mode), 32'd0);

    m_start();
    m_write_byte(8'h84, ack);
    check_eq("post_rst_addr_ack", 32'(ack), 32'(I2C_ACK));
    m_write_byte(8'h5A, ack);
    check_eq("post_rst_data_ack", 32'(ack), 32'(I2C_ACK));
    check_eq("post_rst_rx_data", 32'(hif.rx_data), 32'h5A);
    m_stop();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached with %0d checks done", n_checks);
    $fatal(1);
  end

endmodule

// File: doc/i2c_slave.md
# i2c_slave

I2C target-side (slave) controller: the responding end of the I2C bus driven by the team's I2C master core. It oversamples SCL/SDA on the system clock, detects START/STOP, matches a 7-bit device address and ACKs it, and delivers received bytes to the host. On reads it requests bytes from the host and stretches SCL until the host supplies each one. It sits under a slot wrapper or drives a local register file directly.

## Interface
- DEV_ADDR, 7'h42, 7-bit bus address this target responds to
- clk  input  1  system clock, ≥ 16× SCL bit rate
- reset  input  1  synchronous, active-low reset (one clock; polarity and synchronicity fixed)
- scl  inout (tri)  1  bus clock; driven only low (clock stretch), otherwise Z
- sda  inout (tri)  1  bus data; driven only low, otherwise Z
- rx_data  output  8  last byte written by master; stable until next rx_tick
- rx_tick  output  1  one-cycle pulse, rx_data valid
- tx_req  output  1  level; target needs next read byte (SCL held low meanwhile)
- tx_data  input  8  byte for master read, sampled when tx_req & tx_valid
- tx_valid  input  1  host handshake for tx_data
- start_tick  output  1  pulse on START/repeated START
- stop_tick  output  1  pulse on STOP
- nack_tick  output  1  pulse when master NACKs a read byte
- rd_mode  output  1  R/W bit of current matched transaction (1 = read)
- busy  output  1  high from address match until STOP/START

## Operation
- Pins pass through 2-FF synchronizers plus previous-sample register; edges/events derived from synchronized values only.
- START: SDA fall while SCL high → ADDR from any state, bit counter = 0, release SDA/SCL, pulse start_tick. STOP: SDA rise while SCL high → IDLE, release lines, pulse stop_tick. START/STOP override every state, including TX_WAIT.
- Bits sampled on SCL rising edge, MSB first; SDA changed only on SCL falling edge.
- States: IDLE, ADDR, ADDR_ACK, RX, RX_ACK, TX_WAIT, TX, TX_ACK, IGNORE.
- ADDR: shift 8 bits. Match on bits[7:1] == DEV_ADDR → at 8th-bit SCL fall drive SDA low, ADDR_ACK, latch rd_mode, busy=1. Mismatch → IGNORE (lines released until START/STOP).
- ADDR_ACK: at next SCL fall release SDA; rd_mode=0 → RX; rd_mode=1 → TX_WAIT.
- RX: shift 8 bits; after 8th rising edge update rx_data and pulse rx_tick; at 8th-bit SCL fall drive ACK → RX_ACK; next SCL fall release SDA → RX. Target always ACKs data.
- TX_WAIT: drive SCL low, tx_req=1. On tx_req & tx_valid: load shifter with tx_data, drive SDA = bit7 (low or Z), release SCL next cycle, tx_req=0 → TX.
- TX: on each SCL fall present next bit; after 8th bit's SCL fall release SDA → TX_ACK.
- TX_ACK: sample SDA on SCL rise: 0 → at SCL fall go TX_WAIT; 1 → pulse nack_tick, IGNORE.
- IGNORE: lines released; rd_mode/busy hold until START/STOP, which clear busy.

## Timing
- Reset (reset=0 at clk edge): state IDLE, scl/sda Z, rx_data=0, all ticks 0, tx_req=0, rd_mode=0, busy=0; mid-transaction reset releases both lines in the same cycle.
- Pin-to-event latency: 3 clk cycles (2 sync + edge register); SDA drive/release registered, valid ≤1 cycle after detected SCL fall.
- rx_tick: 1 cycle after 8th detected SCL rising edge of a data byte.
- tx_req asserts 1 cycle after entering TX_WAIT; SCL low is asserted same cycle as state entry. tx_valid may be held high beforehand; acceptance occurs on first cycle both high.
- SCL released exactly 1 cycle after acceptance; SDA set ≥1 cycle before release (setup guaranteed).
- Simultaneous STOP and tx_valid: STOP wins, byte discarded, tx_req drops.
- Bit counter 3-bit, wraps 7→0 at byte boundary; no other arithmetic.

## Structure
- Package i2c_pkg: slave state enum typedef, ACK/NACK constants (1'b0/1'b1), shared with master-side code.
- Sub-module i2c_sync_edge: 2-FF sync + rise/fall pulses; instantiated for SCL and SDA.
- Open-drain outputs as tri assigns from internal scl_low/sda_low regs.

## Test plan
- Master writes addr 0x42 W, data 0xA5, 0x3C, STOP → ACK on addr and both bytes; rx_tick twice with rx_data 0xA5 then 0x3C; stop_tick once; busy falls.
- Address 0x43 W → SDA never driven low; no rx_tick; busy stays 0 until STOP.
- Read addr 0x42 R, host tx_valid 20 cycles after tx_req with 0x96 → SCL held low 20+ cycles; master reads 0x96; master NACK → nack_tick, no further tx_req.
- Read two bytes 0x01, 0xFE with master ACK then NACK → two tx_req handshakes, correct bits on bus, nack_tick after second byte.
- Write 0x11 then repeated START + addr 0x42 R → start_tick twice, rd_mode 0→1, tx_req asserted.
- reset low during TX_WAIT (SCL held low) → SCL/SDA Z next cycle, tx_req=0, state IDLE; next transaction ACKs normally.
